div4_seq: RTL and testbench
===========================

DIV4_SEQ -- requirements
Module: div4_seq

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have ports: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have ports: start  input  1  request; sampled only when busy=0.
REQ-004 SHALL have ports: a  input  8  unsigned dividend; captured on accepted start.
REQ-005 SHALL have ports: b  input  4  unsigned divisor; captured on accepted start.
REQ-006 SHALL have ports: busy  output  1  high while a division is in progress.
REQ-007 SHALL have ports: done  output  1  one-cycle pulse when quotient/remainder become valid.
REQ-008 SHALL have ports: quo  output  8  unsigned quotient.
REQ-009 SHALL have ports: rem  output  4  unsigned remainder.
REQ-010 SHALL have, only when DIV4_SEQ_DIVZERO_EN is defined: div_zero  output  1  set with done when b=0; held with quo/rem.

Function
REQ-011 SHALL compute a = quo*b + rem with rem < b for b != 0 (inverse of the team's 4x4 multiplier; 8-bit quotient, so no overflow).
REQ-012 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-013 IDLE: start=1 at edge E0 SHALL capture a and b, clear the working registers, and enter CALC; busy=1 from E0.
REQ-014 CALC SHALL perform one restoring step per clock, MSB first: partial remainder (5-bit) = {rem,next dividend bit}; if >= {1'b0,b}, subtract b and shift 1 into quo, else shift 0.
REQ-015 CALC SHALL last exactly 8 clocks, tracked by a 3-bit step counter, and then enter DONE at edge E8.
REQ-016 DONE SHALL last one cycle: done=1, busy=0, quo/rem final; it SHALL return to IDLE at the next edge.
REQ-017 Latency SHALL be fixed: done is high in the cycle after E8, for every operand value.
REQ-018 quo/rem SHALL hold their last result until the next accepted start; they SHALL NOT be valid while busy=1.
REQ-019 start while busy=1 or in DONE SHALL be ignored; a and b changes after capture SHALL have no effect.
REQ-020 start held high continuously SHALL begin a new division on the edge after DONE, giving back-to-back operation every 10 cycles.
REQ-021 b=0 SHALL give quo=8'hFF and rem=a[3:0]; the datapath SHALL produce this result naturally.
REQ-022 a=0 SHALL give quo=0 and rem=0 for any b != 0.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, quo=0, rem=0, step counter=0, and div_zero=0 when present.
REQ-024 Reset SHALL take priority over start at the same edge.
REQ-025 Reset during CALC or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-026 Macro DIV4_SEQ_DIVZERO_EN defined: b=0 SHALL skip CALC and go IDLE -> DONE at E0+1, with quo=8'hFF, rem=a[3:0], and div_zero=1.
REQ-027 Macro DIV4_SEQ_DIVZERO_EN undefined: the div_zero port SHALL be absent, and b=0 SHALL take the normal 8-step path and fixed latency per REQ-021.

Verification
REQ-028 Reset, then a=200, b=7, start pulse -> done exactly in the cycle after E8; quo=28, rem=4; busy high for E0..E8.
REQ-029 Sweep a=255/b=1, a=15/b=15, a=0/b=5 -> (255,0), (1,0), (0,0); done pulse width 1 cycle each.
REQ-030 a=8'hA7, b=0 -> quo=8'hFF, rem=7; without the macro done follows E8; with the macro done follows E0+1 and div_zero=1.
REQ-031 Start a=100/b=9, pulse start again with a=50/b=3 during CALC -> only 11 r1 reported; no second done.
REQ-032 Assert rst_n=0 at step 4 of a=200/b=7 -> busy=0, quo=0, rem=0, no done; the next start with a=99/b=10 -> 9 r9.
REQ-033 Random a and b over 1000 operations with start held high -> every result matches a/b and a%b; done every 10 cycles.

Source files
------------

// File: rtl/div4_seq.sv
// div4_seq: 8-bit by 4-bit sequential restoring divider, one quotient bit per clock.
// Defining DIV4_SEQ_DIVZERO_EN adds the div_zero output and a one-cycle path for b=0.
module div4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] quo,
  output logic [3:0] rem
`ifdef DIV4_SEQ_DIVZERO_EN
  ,
  output logic       div_zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [7:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic [2:0] step_q, step_d;
  logic [4:0] part;
  logic [3:0] diff;
  logic       ge;
`ifdef DIV4_SEQ_DIVZERO_EN
  logic       dz_q, dz_d;
`endif

  // Restoring step; the difference always fits in 4 bits when ge is set.
  assign part = {rem_q, dvd_q[7]};
  assign ge   = (part >= {1'b0, dvs_q});
  assign diff = part[3:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    step_d  = step_q;
`ifdef DIV4_SEQ_DIVZERO_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          quo_d   = 8'd0;
          rem_d   = 4'd0;
          step_d  = 3'd0;
`ifdef DIV4_SEQ_DIVZERO_EN
          dz_d    = 1'b0;
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
`ifdef DIV4_SEQ_DIVZERO_EN
        if (dvs_q == 4'd0) begin
          quo_d   = 8'hFF;
          rem_d   = dvd_q[3:0];
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else
`endif
        begin
          dvd_d  = {dvd_q[6:0], 1'b0};
          quo_d  = {quo_q[6:0], ge};
          rem_d  = ge ? diff : part[3:0];
          step_d = step_q + 3'd1;
          if (step_q == 3'd7) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
      step_q  <= 3'd0;
`ifdef DIV4_SEQ_DIVZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
`ifdef DIV4_SEQ_DIVZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
`ifdef DIV4_SEQ_DIVZERO_EN
  assign div_zero = dz_q;
`endif

endmodule

// File: tb/tb_div4_seq.sv
// tb_div4_seq: directed and randomized checks of div4_seq against a plain a/b, a%b model.
// Honours DIV4_SEQ_DIVZERO_EN the same way as the design.
module tb_div4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] quo;
  logic [3:0] rem;
`ifdef DIV4_SEQ_DIVZERO_EN
  logic       div_zero;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = -1;

  div4_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .quo   (quo),
    .rem   (rem)
`ifdef DIV4_SEQ_DIVZERO_EN
    ,
    .div_zero (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: division rules; b=0 yields all-ones quotient and the low dividend nibble.
  function automatic logic [11:0] ref_div(input logic [7:0] av, input logic [3:0] bv);
    int q;
    int r;
    if (bv == 4'd0) begin
      q = 255;
      r = int'(av) % 16;
    end else begin
      q = int'(av) / int'(bv);
      r = int'(av) % int'(bv);
    end
    return {8'(q), 4'(r)};
  endfunction

  function automatic int exp_latency(input logic [3:0] bv);
`ifdef DIV4_SEQ_DIVZERO_EN
    return (bv == 4'd0) ? 1 : 8;
`else
    if (bv == 4'd0) return 8;
    return 8;
`endif
  endfunction

  // One division: E0 accept, then wait for done with a bounded loop.
  // inj_at >= 0 pulses start with other operands during the busy phase.
  task automatic run_op(input logic [7:0] av, input logic [3:0] bv, input int inj_at,
                        input bit hold, output logic [7:0] q_o, output logic [3:0] r_o);
    logic [11:0] res;
    int lat;
    int elat;
    res  = ref_div(av, bv);
    elat = exp_latency(bv);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    a = 8'($urandom);
    b = 4'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      chk("busy_calc", 32'(busy), 32'd1);
      if (lat == inj_at) begin
        start = 1'b1;
        a = 8'd50;
        b = 4'd3;
      end
      tick();
      lat++;
      if (!hold) start = 1'b0;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("busy_done", 32'(busy), 32'd0);
    chk("quo", 32'(quo), 32'(res[11:4]));
    chk("rem", 32'(rem), 32'(res[3:0]));
`ifdef DIV4_SEQ_DIVZERO_EN
    chk("div_zero", 32'(div_zero), 32'(bv == 4'd0));
`endif
    if (hold && last_done >= 0) chk("period", 32'(cyc - last_done), 32'(elat + 2));
    last_done = cyc;
    q_o = quo;
    r_o = rem;
    tick();
    chk("done_width", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("quo_hold", 32'(quo), 32'(res[11:4]));
    chk("rem_hold", 32'(rem), 32'(res[3:0]));
    $display("op a=%0d b=%0d -> quo=%0d rem=%0d latency=%0d", av, bv, q_o, r_o, lat);
  endtask

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'd0;
    b = 4'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quo", 32'(quo), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
`ifdef DIV4_SEQ_DIVZERO_EN
    chk("rst_div_zero", 32'(div_zero), 32'd0);
`endif

    // Reset wins over a simultaneous start.
    start = 1'b1;
    a = 8'd5;
    b = 4'd1;
    tick();
    chk("rst_prio_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("rst_prio_idle", 32'(busy), 32'd0);

    run_op(8'd200, 4'd7, -1, 1'b0, q, r);
    chk("d200_7_quo", 32'(q), 32'd28);
    chk("d200_7_rem", 32'(r), 32'd4);
    run_op(8'd255, 4'd1, -1, 1'b0, q, r);
    run_op(8'd15, 4'd15, -1, 1'b0, q, r);
    run_op(8'd0, 4'd5, -1, 1'b0, q, r);
    chk("d0_5_quo", 32'(q), 32'd0);
    run_op(8'hA7, 4'd0, -1, 1'b0, q, r);
    chk("dA7_0_quo", 32'(q), 32'hFF);
    chk("dA7_0_rem", 32'(r), 32'd7);

    // A second start during CALC is ignored: one done only.
    run_op(8'd100, 4'd9, 3, 1'b0, q, r);
    chk("d100_9_quo", 32'(q), 32'd11);
    chk("d100_9_rem", 32'(r), 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk("no_second_done", 32'(done), 32'd0);
      chk("no_second_busy", 32'(busy), 32'd0);
      tick();
    end

    // Abort mid-calculation.
    a = 8'd200;
    b = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quo", 32'(quo), 32'd0);
    chk("abort_rem", 32'(rem), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_op(8'd99, 4'd10, -1, 1'b0, q, r);
    chk("d99_10_quo", 32'(q), 32'd9);
    chk("d99_10_rem", 32'(r), 32'd9);

    // Back-to-back with start held high.
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 4'($urandom), -1, 1'b1, q, r);
    end
    start = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
